// File: rtl/cbfp_block_min_tracker.sv
// cbfp_block_min_tracker
// Finds the minimum magnitude index over one CBFP block (BLK_BEATS beats of
// LANES lanes each) and reports it, clamped to SAT_MAX, as the block shift.
//
// Pipeline:
//   stage A - lane-minimum of the incoming beat via a balanced comparator
//             tree, registered together with beat-valid and last-beat flags.
//   stage B - running block minimum (acc); on the last beat the clamped
//             result is registered to min_mag with a one-cycle out_valid.
//
// Ports:
//   clk       in   single clock, rising edge
//   rstn      in   asynchronous active-low reset
//   in_valid  in   mag_in holds a valid beat this cycle
//   mag_in    in   LANES x MAG_WIDTH unsigned magnitude indices (lane 0 = LSBs)
//   sync_clr  in   synchronous discard of any partial/in-flight block
//   out_valid out  one-cycle pulse when a block result is presented
//   min_mag   out  clamped block minimum, held between pulses
//   blk_cnt   out  count of completed blocks, wraps 255 -> 0
module cbfp_block_min_tracker #(
    parameter int MAG_WIDTH = 6,
    parameter int LANES     = 16,
    parameter int BLK_BEATS = 4,
    parameter int SAT_MAX   = (1 << MAG_WIDTH) - 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    input  logic [LANES*MAG_WIDTH-1:0]   mag_in,
    input  logic                         sync_clr,
    output logic                         out_valid,
    output logic [MAG_WIDTH-1:0]         min_mag,
    output logic [7:0]                   blk_cnt
);

    localparam int LVLS  = $clog2(LANES);
    localparam int CNT_W = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BLK_BEATS - 1);
    // A SAT_MAX at or above the full index range never clamps anything.
    localparam logic [MAG_WIDTH-1:0] SAT_C =
        (SAT_MAX >= (1 << MAG_WIDTH) - 1) ? {MAG_WIDTH{1'b1}} : SAT_MAX[MAG_WIDTH-1:0];

    function automatic logic [MAG_WIDTH-1:0] min2(input logic [MAG_WIDTH-1:0] a,
                                                  input logic [MAG_WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Balanced comparator tree: level 0 is the raw beat, each following level
    // halves the number of candidates; level LVLS holds the lane-minimum.
    genvar gl, gi;
    for (gl = 0; gl <= LVLS; gl++) begin : g_lvl
        localparam int N = LANES >> gl;
        logic [N*MAG_WIDTH-1:0] w_v;
        if (gl == 0) begin : g_src
            assign w_v = mag_in;
        end else begin : g_red
            for (gi = 0; gi < N; gi++) begin : g_cmp
                assign w_v[gi*MAG_WIDTH +: MAG_WIDTH] =
                    min2(g_lvl[gl-1].w_v[(2*gi)*MAG_WIDTH +: MAG_WIDTH],
                         g_lvl[gl-1].w_v[(2*gi+1)*MAG_WIDTH +: MAG_WIDTH]);
            end
        end
    end

    logic [MAG_WIDTH-1:0] w_lane_min;
    assign w_lane_min = g_lvl[LVLS].w_v[MAG_WIDTH-1:0];

    logic [CNT_W-1:0]     r_beat_cnt;
    logic                 r_a_valid;
    logic                 r_a_last;
    logic [MAG_WIDTH-1:0] r_a_min;

    // Stage A: capture lane-minimum and beat position; sync_clr drops the beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat_cnt <= '0;
            r_a_valid  <= 1'b0;
            r_a_last   <= 1'b0;
            r_a_min    <= '0;
        end else if (sync_clr) begin
            r_beat_cnt <= '0;
            r_a_valid  <= 1'b0;
            r_a_last   <= 1'b0;
        end else begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_min    <= w_lane_min;
                r_a_last   <= (r_beat_cnt == BEAT_LAST);
                r_beat_cnt <= (r_beat_cnt == BEAT_LAST) ? '0 : r_beat_cnt + CNT_W'(1);
            end else begin
                r_a_last <= 1'b0;
            end
        end
    end

    logic [MAG_WIDTH-1:0] r_acc;
    logic                 r_acc_empty;
    logic                 r_out_valid;
    logic [MAG_WIDTH-1:0] r_min_mag;
    logic [7:0]           r_blk_cnt;

    // An empty accumulator means this beat opens the block, so it loads directly.
    logic [MAG_WIDTH-1:0] w_merge;
    logic [MAG_WIDTH-1:0] w_clamped;
    assign w_merge   = r_acc_empty ? r_a_min : min2(r_acc, r_a_min);
    assign w_clamped = (w_merge > SAT_C) ? SAT_C : w_merge;

    // Stage B: fold beat minima into acc and publish the clamped result on the last beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc       <= '0;
            r_acc_empty <= 1'b1;
            r_out_valid <= 1'b0;
            r_min_mag   <= '0;
            r_blk_cnt   <= 8'd0;
        end else if (sync_clr) begin
            // Kills any block still in flight; the published result stays.
            r_acc_empty <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_a_valid & r_a_last;
            if (r_a_valid) begin
                if (r_a_last) begin
                    r_min_mag   <= w_clamped;
                    r_blk_cnt   <= r_blk_cnt + 8'd1;
                    r_acc_empty <= 1'b1;
                end else begin
                    r_acc       <= w_merge;
                    r_acc_empty <= 1'b0;
                end
            end else begin
                r_acc_empty <= r_acc_empty;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign min_mag   = r_min_mag;
    assign blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_cbfp_block_min_tracker.sv
// Bench for cbfp_block_min_tracker. Three instances share one stimulus:
//   u0 default parameters, u1 SAT_MAX=10, u2 BLK_BEATS=1.
module tb_cbfp_block_min_tracker;

    localparam int W = 6;
    localparam int L = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstn;
    logic           in_valid;
    logic           sync_clr;
    logic [L*W-1:0] mag_in;
    logic           ov [3];
    logic [W-1:0]   mm [3];
    logic [7:0]     bc [3];

    cbfp_block_min_tracker u0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .mag_in(mag_in), .sync_clr(sync_clr),
        .out_valid(ov[0]), .min_mag(mm[0]), .blk_cnt(bc[0]));

    cbfp_block_min_tracker #(.SAT_MAX(10)) u1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .mag_in(mag_in), .sync_clr(sync_clr),
        .out_valid(ov[1]), .min_mag(mm[1]), .blk_cnt(bc[1]));

    cbfp_block_min_tracker #(.BLK_BEATS(1)) u2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .mag_in(mag_in), .sync_clr(sync_clr),
        .out_valid(ov[2]), .min_mag(mm[2]), .blk_cnt(bc[2]));

    int n_checks = 0;
    int n_errors = 0;
    int n_pulse2 = 0;

    // Reference model: beat minima of the open block are queued; a full
    // block becomes a pending result that is shown one edge later.
    int mq [3][$];
    int BB  [3] = '{4, 4, 1};
    int SAT [3] = '{63, 10, 63};
    bit m_pend [3];
    int m_pmin [3];
    bit e_ov   [3];
    int e_min  [3];
    int e_cnt  [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int beat_min(input logic [L*W-1:0] m);
        int r = 63;
        for (int i = 0; i < L; i++)
            if (int'(m[i*W +: W]) < r) r = int'(m[i*W +: W]);
        return r;
    endfunction

    // Random beat whose smallest lane is exactly m, at a random lane.
    function automatic logic [L*W-1:0] make_mag(input int m);
        logic [L*W-1:0] r;
        int p = int'($urandom_range(0, L - 1));
        for (int i = 0; i < L; i++)
            r[i*W +: W] = (i == p) ? W'(m) : W'(m + int'($urandom_range(0, 63 - m)));
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            m_pend[d] = 1'b0;
            m_pmin[d] = 0;
            e_ov[d]   = 1'b0;
            e_min[d]  = 0;
            e_cnt[d]  = 0;
        end
    endtask

    task automatic model_edge();
        int bm;
        int mn;
        if (!rstn) begin
            model_reset();
        end else begin
            bm = beat_min(mag_in);
            for (int d = 0; d < 3; d++) begin
                if (sync_clr) begin
                    e_ov[d]   = 1'b0;
                    m_pend[d] = 1'b0;
                    mq[d].delete();
                end else begin
                    e_ov[d] = m_pend[d];
                    if (m_pend[d]) begin
                        e_min[d] = m_pmin[d];
                        e_cnt[d] = (e_cnt[d] + 1) % 256;
                    end
                    m_pend[d] = 1'b0;
                    if (in_valid) begin
                        mq[d].push_back(bm);
                        if (mq[d].size() == BB[d]) begin
                            mn = 63;
                            foreach (mq[d][k]) if (mq[d][k] < mn) mn = mq[d][k];
                            m_pmin[d] = (mn > SAT[d]) ? SAT[d] : mn;
                            m_pend[d] = 1'b1;
                            mq[d].delete();
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("out_valid[u%0d]", d), 32'(ov[d]), 32'(e_ov[d]));
            check($sformatf("min_mag[u%0d]", d),   32'(mm[d]), 32'(e_min[d]));
            check($sformatf("blk_cnt[u%0d]", d),   32'(bc[d]), 32'(e_cnt[d]));
        end
    endtask

    // One clock: model advances on the rising edge, outputs read on the falling one.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (ov[2] === 1'b1) n_pulse2++;
        compare_all();
    endtask

    task automatic set_beat(input bit v, input bit c, input int m);
        in_valid = v;
        sync_clr = c;
        mag_in   = make_mag(m);
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ov[u%0d]", d),  32'(ov[d]), 32'd0);
            check($sformatf("rst_min[u%0d]", d), 32'(mm[d]), 32'd0);
            check($sformatf("rst_cnt[u%0d]", d), 32'(bc[d]), 32'd0);
        end
        model_reset();
        set_beat(1'b0, 1'b0, 0);
        cycle();
        rstn = 1'b1;
    endtask

    typedef struct {
        bit v;
        bit c;
        int m;
        bit e_ov;
        int e_min;
        int e_cnt;
        int e_sat;
    } vec_t;

    function automatic vec_t mk(input bit v, input bit c, input int m, input bit eo,
                                input int emin, input int ecnt, input int esat);
        vec_t r;
        r.v = v; r.c = c; r.m = m; r.e_ov = eo; r.e_min = emin; r.e_cnt = ecnt; r.e_sat = esat;
        return r;
    endfunction

    initial begin
        vec_t tbl [24];
        int   bm [4] = '{9, 5, 7, 12};

        // Expected u0 outputs and u1 min_mag after each row's edge.
        tbl[0]  = mk(1, 0,  9, 0,  0, 0,  0);
        tbl[1]  = mk(1, 0,  5, 0,  0, 0,  0);
        tbl[2]  = mk(1, 0,  7, 0,  0, 0,  0);
        tbl[3]  = mk(1, 0, 12, 0,  0, 0,  0);
        tbl[4]  = mk(0, 0,  0, 1,  5, 1,  5);
        tbl[5]  = mk(0, 0,  0, 0,  5, 1,  5);
        tbl[6]  = mk(1, 0, 63, 0,  5, 1,  5);
        tbl[7]  = mk(1, 0, 63, 0,  5, 1,  5);
        tbl[8]  = mk(1, 0, 63, 0,  5, 1,  5);
        tbl[9]  = mk(1, 0, 63, 0,  5, 1,  5);
        tbl[10] = mk(0, 0,  0, 1, 63, 2, 10);
        tbl[11] = mk(1, 0,  3, 0, 63, 2, 10);
        tbl[12] = mk(1, 0, 40, 0, 63, 2, 10);
        tbl[13] = mk(1, 0, 50, 0, 63, 2, 10);
        tbl[14] = mk(1, 0, 60, 0, 63, 2, 10);
        tbl[15] = mk(0, 0,  0, 1,  3, 3,  3);
        tbl[16] = mk(1, 0,  1, 0,  3, 3,  3);
        tbl[17] = mk(1, 0,  1, 0,  3, 3,  3);
        tbl[18] = mk(1, 1,  1, 0,  3, 3,  3);
        tbl[19] = mk(1, 0, 20, 0,  3, 3,  3);
        tbl[20] = mk(1, 0, 21, 0,  3, 3,  3);
        tbl[21] = mk(1, 0, 22, 0,  3, 3,  3);
        tbl[22] = mk(1, 0, 23, 0,  3, 3,  3);
        tbl[23] = mk(0, 0,  0, 1, 20, 4, 10);

        rstn     = 1'b0;
        in_valid = 1'b0;
        sync_clr = 1'b0;
        mag_in   = '0;
        model_reset();
        @(negedge clk);
        pulse_reset();

        // Directed blocks: plain, saturating, and aborted by sync_clr.
        for (int i = 0; i < 24; i++) begin
            set_beat(tbl[i].v, tbl[i].c, tbl[i].m);
            cycle();
            check($sformatf("tbl%0d_ov", i),  32'(ov[0]), 32'(tbl[i].e_ov));
            check($sformatf("tbl%0d_min", i), 32'(mm[0]), 32'(tbl[i].e_min));
            check($sformatf("tbl%0d_cnt", i), 32'(bc[0]), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_sat", i), 32'(mm[1]), 32'(tbl[i].e_sat));
        end

        // Same block with idle gaps; result follows the final beat.
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(0, 3)) begin
                    set_beat(1'b0, 1'b0, 0);
                    cycle();
                end
                set_beat(1'b1, 1'b0, bm[b]);
                cycle();
            end
            set_beat(1'b0, 1'b0, 0);
            cycle();
            check("gap_ov", 32'(ov[0]), 32'd1);
            check("gap_min", 32'(mm[0]), 32'd5);
            cycle();
            check("gap_ov_drop", 32'(ov[0]), 32'd0);
        end

        // Random traffic with occasional sync_clr.
        for (int i = 0; i < 1500; i++) begin
            set_beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                     int'($urandom_range(0, 63)));
            cycle();
        end

        // Single-beat blocks: 300 back-to-back results, counter wraps.
        set_beat(1'b0, 1'b0, 0);
        cycle();
        pulse_reset();
        n_pulse2 = 0;
        for (int i = 0; i < 300; i++) begin
            set_beat(1'b1, 1'b0, int'($urandom_range(0, 63)));
            cycle();
        end
        set_beat(1'b0, 1'b0, 0);
        cycle();
        cycle();
        check("bb1_pulses", 32'(n_pulse2), 32'd300);
        check("bb1_wrap", 32'(bc[2]), 32'd44);

        // Reset in mid-stream, then counting restarts from zero.
        for (int i = 0; i < 100; i++) begin
            set_beat(1'b1, 1'b0, int'($urandom_range(0, 63)));
            cycle();
        end
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            set_beat(1'b1, 1'b0, int'($urandom_range(0, 63)));
            cycle();
        end
        set_beat(1'b0, 1'b0, 0);
        cycle();
        cycle();
        check("bb1_restart", 32'(bc[2]), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
